demux_1x2_simple_seq: RTL

- Sequential 1-to-2 demultiplexer with per-branch output buffering; the distribution counterpart of the 2x1 sequential mux in NoC routing and tree-reduction paths.
- Steers one input word to the low branch, the high branch, or both (multicast) under command control, or drops it.
- Each branch has its own small FIFO with valid/ready backpressure, so one stalled branch never corrupts the other.

---
 rtl/noc_pkg.sv | 13 +
 rtl/fifo_sync_seq.sv | 58 +++++
 rtl/demux_1x2_simple_seq.sv | 72 +++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: routing command encodings and default payload width.
package noc_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        CMD_DROP  = 2'b00,
        CMD_LOW   = 2'b01,
        CMD_HIGH  = 2'b10,
        CMD_BCAST = 2'b11
    } cmd_e;

endpackage

// File: rtl/fifo_sync_seq.sv
// Single-clock FIFO with registered storage, occupancy count and zeroed output when empty.
module fifo_sync_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [DATA_WIDTH-1:0]         i_din,
    input  logic                          i_pop,
    output logic [DATA_WIDTH-1:0]         o_dout,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;

    assign w_full  = (r_count == DEPTH_C);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    // A full FIFO refuses a push even when it pops in the same cycle.
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/demux_1x2_simple_seq.sv
// 1-to-2 demultiplexer with per-branch FIFOs: drop, unicast low/high, or atomic multicast.
module demux_1x2_simple_seq
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int COMMAND_WIDTH = 2,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic [DATA_WIDTH-1:0]     i_data_bus,
    output logic                      o_ready,
    input  logic                      i_en,
    input  logic [COMMAND_WIDTH-1:0]  i_cmd,
    output logic [1:0]                o_valid,
    output logic [2*DATA_WIDTH-1:0]   o_data_bus,
    input  logic [1:0]                i_ready
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [1:0]                 w_cmd;
    logic [1:0]                 w_tgt;
    logic [1:0]                 w_room;
    logic [1:0]                 w_push;
    logic [1:0]                 w_pop;
    logic [1:0]                 w_empty;
    logic [1:0][CW:0]           w_count;
    logic [1:0][DATA_WIDTH-1:0] w_dout;
    logic                       w_fire;

    assign w_cmd = i_cmd[1:0];

    always_comb begin
        w_tgt = 2'b00;
        case (w_cmd)
            CMD_LOW:   w_tgt = 2'b01;
            CMD_HIGH:  w_tgt = 2'b10;
            CMD_BCAST: w_tgt = 2'b11;
            default:   w_tgt = 2'b00;
        endcase
    end

    // Every targeted branch must have room, so multicast never half-pushes.
    assign o_ready = ~rst & i_en & (&(w_room | ~w_tgt));
    assign w_fire  = i_valid & o_ready;

    for (genvar b = 0; b < 2; b++) begin : g_br
        assign w_room[b]  = (w_count[b] < DEPTH_C);
        assign w_push[b]  = w_fire & w_tgt[b];
        assign w_pop[b]   = o_valid[b] & i_ready[b];
        assign o_valid[b] = ~w_empty[b];
        assign o_data_bus[b*DATA_WIDTH +: DATA_WIDTH] = o_valid[b] ? w_dout[b] : '0;

        fifo_sync_seq #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[b]),
            .i_din   (i_data_bus),
            .i_pop   (w_pop[b]),
            .o_dout  (w_dout[b]),
            .o_empty (w_empty[b]),
            .o_count (w_count[b])
        );
    end

endmodule
